vic_mem_arbiter: RTL and testbench

Single-port memory arbiter sharing one synchronous-read video/system RAM between the raster fetch engine and the 6502 CPU bus. The video port has priority. A consecutive-wait counter guarantees CPU service within a bounded number of cycles. Read data is routed back to the owning requester through a tagged return pipeline. The block sits between the video fetch logic and the RAM that holds screen, colour and character data.

---
 rtl/vic_mem_pkg.sv | 8 +
 rtl/vic_read_return.sv | 34 +++
 rtl/vic_mem_arbiter.sv | 72 +++++++
 tb/tb_vic_mem_arbiter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/vic_mem_pkg.sv
// vic_mem_pkg: shared types and constants for the video/CPU memory arbiter
package vic_mem_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU} owner_t;
    localparam int DEF_AW = 16;
    localparam int DEF_DW = 8;
    localparam int MAX_WAIT_LO = 1;
    localparam int MAX_WAIT_HI = 15;
endpackage

// File: rtl/vic_read_return.sv
// vic_read_return: two-stage owner tag pipeline steering RAM read data to its requester
module vic_read_return
    import vic_mem_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  owner_t        tag_in,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid
);
    owner_t stage1, stage2;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1     <= OWN_NONE;
            stage2     <= OWN_NONE;
            vid_rvalid <= 1'b0;
            cpu_rvalid <= 1'b0;
            vid_rdata  <= '0;
            cpu_rdata  <= '0;
        end else begin
            stage1     <= tag_in;
            stage2     <= stage1;
            vid_rvalid <= stage2 == OWN_VID;
            cpu_rvalid <= stage2 == OWN_CPU;
            if (stage2 == OWN_VID) vid_rdata <= mem_rdata;
            if (stage2 == OWN_CPU) cpu_rdata <= mem_rdata;
        end
    end
endmodule

// File: rtl/vic_mem_arbiter.sv
// vic_mem_arbiter: video-priority single-port RAM arbiter with bounded CPU wait
module vic_mem_arbiter
    import vic_mem_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic [DW-1:0] vid_rdata,
    output logic          vid_rvalid,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    // Out-of-range MAX_WAIT is clamped so the 4-bit counter can always reach it
    localparam int MW = MAX_WAIT < MAX_WAIT_LO ? MAX_WAIT_LO :
                        MAX_WAIT > MAX_WAIT_HI ? MAX_WAIT_HI : MAX_WAIT;
    localparam logic [3:0] WAIT_LIM = 4'(MW);
    logic [3:0] wait_cnt;
    logic       cpu_first;
    owner_t     tag_in;
    always_comb begin
        cpu_first = cpu_req && (!vid_req || wait_cnt == WAIT_LIM);
        cpu_gnt   = cpu_first;
        vid_gnt   = vid_req && !cpu_first;
        tag_in    = vid_gnt ? OWN_VID : (cpu_gnt && !cpu_we) ? OWN_CPU : OWN_NONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_cnt <= '0;
        else if (!cpu_req || cpu_gnt) wait_cnt <= '0;
        else if (wait_cnt != WAIT_LIM) wait_cnt <= wait_cnt + 4'd1;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else if (vid_gnt) begin
            mem_addr <= vid_addr;
            mem_we   <= 1'b0;
        end else if (cpu_gnt) begin
            mem_addr  <= cpu_addr;
            mem_we    <= cpu_we;
            mem_wdata <= cpu_wdata;
        end else begin
            mem_we <= 1'b0;
        end
    end
    vic_read_return #(.DW(DW)) u_ret (
        .clk        (clk),
        .reset      (reset),
        .tag_in     (tag_in),
        .mem_rdata  (mem_rdata),
        .vid_rdata  (vid_rdata),
        .vid_rvalid (vid_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid)
    );
endmodule

// File: tb/tb_vic_mem_arbiter.sv
// tb_vic_mem_arbiter: directed scoreboard bench with a write-first synchronous RAM model
module tb_vic_mem_arbiter;
    logic        clk = 0, reset = 1;
    logic        vid_req = 0, cpu_req = 0, cpu_we = 0;
    logic [15:0] vid_addr = 0, cpu_addr = 0;
    logic [7:0]  cpu_wdata = 0;
    logic        vid_gnt, cpu_gnt, vid_rvalid, cpu_rvalid, mem_we;
    logic [7:0]  vid_rdata, cpu_rdata, mem_wdata, mem_rdata = 0;
    logic [15:0] mem_addr;
    logic [7:0]  ram [65536];
    logic [7:0]  shadow [65536];
    typedef struct { int due; logic [7:0] d; } exp_t;
    exp_t vq[$], cq[$];
    int cyc = 0, n_chk = 0, n_fail = 0;
    bit vd, cd;

    vic_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transfers are recorded at the edge; reads are due two edges later
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            vq.delete();
            cq.delete();
        end else if (vid_req && vid_gnt) begin
            vq.push_back('{cyc + 2, shadow[vid_addr]});
        end else if (cpu_req && cpu_gnt) begin
            if (cpu_we) shadow[cpu_addr] = cpu_wdata;
            else cq.push_back('{cyc + 2, shadow[cpu_addr]});
        end
    end

    always @(negedge clk) begin
        vd = vq.size() > 0 && vq[0].due == cyc;
        cd = cq.size() > 0 && cq[0].due == cyc;
        check("vid_rvalid", vid_rvalid, vd);
        check("cpu_rvalid", cpu_rvalid, cd);
        if (vd) begin
            check("vid_rdata", vid_rdata, vq[0].d);
            void'(vq.pop_front());
        end
        if (cd) begin
            check("cpu_rdata", cpu_rdata, cq[0].d);
            void'(cq.pop_front());
        end
    end

    task automatic drain();
        for (int i = 0; i < 8 && (vq.size() + cq.size()) != 0; i++) @(negedge clk);
        check("drain", vq.size() + cq.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = 8'(i) ^ 8'h3C;
            shadow[i] = ram[i];
        end
        for (int i = 0; i < 4; i++) begin
            ram[16'h1000 + i] = 8'hA0 + 8'(i);
            shadow[16'h1000 + i] = 8'hA0 + 8'(i);
        end
        ram[16'h9000] = 8'h77;
        shadow[16'h9000] = 8'h77;
        vid_req = 1; cpu_req = 1; vid_addr = 16'h1234; cpu_addr = 16'h4321; cpu_wdata = 8'hEE;
        repeat (3) @(negedge clk);
        check("rst_vid_rvalid", vid_rvalid, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_vid_rdata", vid_rdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        // Back-to-back video reads right out of reset
        reset = 0; cpu_req = 0;
        for (int i = 0; i < 4; i++) begin
            vid_addr = 16'h1000 + 16'(i);
            #1 check("vid_gnt_b2b", vid_gnt, 1);
            @(negedge clk);
            check("b2b_mem_addr", mem_addr, 16'h1000 + 16'(i));
            check("b2b_mem_we", mem_we, 0);
        end
        vid_req = 0;
        drain();
        // CPU starved by continuous video traffic is served on the fifth edge
        vid_req = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h9000;
        for (int i = 0; i < 5; i++) begin
            vid_addr = 16'h1100 + 16'(i);
            #1 check("starve_cpu_gnt", cpu_gnt, i == 4);
            check("starve_vid_gnt", vid_gnt, i != 4);
            @(negedge clk);
        end
        check("starve_mem_addr", mem_addr, 16'h9000);
        cpu_req = 0;
        repeat (2) begin
            vid_addr = vid_addr + 16'd1;
            @(negedge clk);
        end
        vid_req = 0;
        drain();
        // Write followed immediately by read of the same address
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 8'h5A;
        #1 check("wr_cpu_gnt", cpu_gnt, 1);
        @(negedge clk);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_addr", mem_addr, 16'h0200);
        check("wr_mem_wdata", mem_wdata, 8'h5A);
        cpu_we = 0;
        @(negedge clk);
        check("rd_mem_we", mem_we, 0);
        cpu_req = 0;
        drain();
        check("wr_rd_cpu_rdata", cpu_rdata, 8'h5A);
        // Dropping cpu_req restarts the wait count
        vid_req = 1; vid_addr = 16'h1002; cpu_req = 1; cpu_addr = 16'h9000;
        repeat (2) begin
            #1 check("drop_cpu_gnt", cpu_gnt, 0);
            @(negedge clk);
        end
        cpu_req = 0;
        @(negedge clk);
        cpu_req = 1;
        for (int i = 0; i < 5; i++) begin
            #1 check("restart_cpu_gnt", cpu_gnt, i == 4);
            @(negedge clk);
        end
        cpu_req = 0; vid_req = 0;
        drain();
        // Reset right after a video transfer kills the in-flight read
        vid_req = 1; vid_addr = 16'h1001;
        @(negedge clk);
        vid_req = 0; reset = 1;
        #1 check("async_vid_rdata", vid_rdata, 0);
        check("async_cpu_rdata", cpu_rdata, 0);
        check("async_mem_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        repeat (4) @(negedge clk);
        check("post_rst_vid_rdata", vid_rdata, 0);
        drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
